lif_neuron_array: RTL
=====================

LIF_NEURON_ARRAY -- requirements
Module: lif_neuron_array

Interface
REQ-001 SHALL have parameter WIDTH, default 16: membrane, current and configuration width (unsigned).
REQ-002 SHALL have parameter N_NEURONS, default 8: neurons time-multiplexed on one shared datapath (>=2).
REQ-003 SHALL have parameter REFRAC_W, default 4: refractory counter width.
REQ-004 SHALL have port clk  input  1  clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port step_start  input  1  single-cycle pulse that begins one timestep.
REQ-007 SHALL have port in_valid  input  1  input current valid.
REQ-008 SHALL have port in_ready  output  1  block accepts a current this cycle.
REQ-009 SHALL have port in_current  input  WIDTH  synaptic current for the neuron currently indexed.
REQ-010 SHALL have port leak_factor  input  WIDTH  leak fraction, Q0.WIDTH.
REQ-011 SHALL have port threshold  input  WIDTH  firing threshold.
REQ-012 SHALL have port reset_potential  input  WIDTH  potential loaded after a spike.
REQ-013 SHALL have port refrac_period  input  REFRAC_W  timesteps a neuron ignores input after a spike.
REQ-014 SHALL have port busy  output  1  timestep in progress.
REQ-015 SHALL have port step_done  output  1  single-cycle pulse: timestep complete, spikes valid.
REQ-016 SHALL have port spikes  output  N_NEURONS  spike vector of last completed timestep; bit i = neuron i.
REQ-017 SHALL have port rd_idx  input  clog2(N_NEURONS)  monitor neuron select.
REQ-018 SHALL have port rd_potential  output  WIDTH  stored potential of neuron rd_idx, combinational read.

Function
REQ-019 SHALL implement FSM IDLE -> UPDATE on step_start; UPDATE -> DONE on acceptance of neuron N_NEURONS-1; DONE -> IDLE unconditionally after one cycle.
REQ-020 SHALL assert in_ready only in UPDATE; a current is accepted when in_valid && in_ready.
REQ-021 SHALL apply accepted currents to neurons in order 0..N_NEURONS-1 via an internal index, reset to 0 on entering UPDATE.
REQ-022 SHALL, for a non-refractory neuron, compute leak = (v * leak_factor) >> WIDTH using a 2*WIDTH-bit product, then next = v + in_current - leak in WIDTH+1 bits, saturated to 2^WIDTH-1.
REQ-023 SHALL compare the newly computed next (not the stale v) against threshold; next >= threshold: spike bit set, v <= reset_potential, refractory counter <= refrac_period; else v <= next, spike bit clear.
REQ-024 SHALL, for a neuron with refractory counter > 0, ignore in_current, hold v, clear its spike bit, and decrement the counter by 1.
REQ-025 SHALL write the updated v, counter and spike bit on the acceptance edge (one-cycle latency).
REQ-026 SHALL assert step_done for exactly the DONE cycle; spikes SHALL update in that cycle only and hold until the next DONE.
REQ-027 SHALL assert busy in UPDATE and DONE.
REQ-028 SHALL ignore step_start when not in IDLE.
REQ-029 SHALL stall indefinitely in UPDATE while in_valid is low, with no state change.
REQ-030 SHALL sample leak_factor, threshold, reset_potential and refrac_period at each acceptance; no latching.
REQ-031 SHALL fire on every non-refractory update when threshold = 0.
REQ-032 SHALL never underflow, since leak <= v for any leak_factor <= 2^WIDTH-1.

Reset
REQ-033 SHALL on reset, asynchronously: FSM to IDLE; all potentials, refractory counters and spikes to 0; in_ready, busy and step_done to 0; index to 0.
REQ-034 SHALL abort an in-progress timestep on reset: partial updates discarded, no step_done.

Verification (WIDTH=16, N_NEURONS=4)
REQ-035 SHALL verify integrate-and-fire: leak 0, threshold 100, reset_potential 10, refrac 0, current 60 for all neurons -> step1 spikes 0000, v=60; step2 spikes 1111, v=10.
REQ-036 SHALL verify refractory behaviour: as REQ-035 with refrac 2 -> steps 3-4 spikes 0000, v=10; step5 v=70.
REQ-037 SHALL verify leak: v=0x8000, leak 0x8000, current 0, threshold 0xFFFF -> v=0x4000, no spike.
REQ-038 SHALL verify saturation: v=0xFFF0, current 0x0100, leak 0, threshold 0xFFFF -> next saturates to 0xFFFF, spike, v=reset_potential.
REQ-039 SHALL verify stall and ignore: in_valid low 5 cycles mid-step, plus step_start pulsed while busy -> no update, no restart; step_done 1 cycle after 4th acceptance.
REQ-040 SHALL verify reset mid-step after 2 acceptances -> all rd_potential 0, spikes 0, step_done never pulses.

Source files
------------

// File: rtl/lif_neuron_array.sv
// lif_neuron_array: time-multiplexed leaky integrate-and-fire neurons sharing one update datapath.
// One timestep walks neurons 0..N_NEURONS-1, consuming one input current per neuron.
module lif_neuron_array #(
    parameter int WIDTH = 16,
    parameter int N_NEURONS = 8,
    parameter int REFRAC_W = 4,
    localparam int IW = $clog2(N_NEURONS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 step_start,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_current,
    input  logic [WIDTH-1:0]     leak_factor,
    input  logic [WIDTH-1:0]     threshold,
    input  logic [WIDTH-1:0]     reset_potential,
    input  logic [REFRAC_W-1:0]  refrac_period,
    output logic                 busy,
    output logic                 step_done,
    output logic [N_NEURONS-1:0] spikes,
    input  logic [IW-1:0]        rd_idx,
    output logic [WIDTH-1:0]     rd_potential
);
    localparam logic [1:0] IDLE = 2'd0, UPDATE = 2'd1, DONE = 2'd2;

    logic [1:0]           state;
    logic [IW-1:0]        idx;
    logic [WIDTH-1:0]     v [N_NEURONS];
    logic [REFRAC_W-1:0]  rc [N_NEURONS];
    logic [N_NEURONS-1:0] spk;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     sat;
    logic                 refr, fire, accept, last;

    assign in_ready     = state == UPDATE;
    assign busy         = state != IDLE;
    assign step_done    = state == DONE;
    assign rd_potential = v[rd_idx];
    assign accept       = in_valid && in_ready;
    assign last         = idx == IW'(N_NEURONS - 1);

    // leak never exceeds v, so the subtraction cannot wrap below zero
    always_comb begin
        prod = {{WIDTH{1'b0}}, v[idx]} * {{WIDTH{1'b0}}, leak_factor};
        sum  = {1'b0, v[idx]} + {1'b0, in_current} - {1'b0, prod[2*WIDTH-1:WIDTH]};
        sat  = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
        refr = rc[idx] != '0;
        fire = !refr && sat >= threshold;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            spk    <= '0;
            spikes <= '0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v[i]  <= '0;
                rc[i] <= '0;
            end
        end else begin
            if (state == IDLE && step_start) begin
                state <= UPDATE;
                idx   <= '0;
            end
            if (state == DONE)
                state <= IDLE;
            if (accept) begin
                idx <= last ? '0 : idx + 1'b1;
                if (refr) begin
                    rc[idx]  <= rc[idx] - 1'b1;
                    spk[idx] <= 1'b0;
                end else if (fire) begin
                    v[idx]   <= reset_potential;
                    rc[idx]  <= refrac_period;
                    spk[idx] <= 1'b1;
                end else begin
                    v[idx]   <= sat;
                    spk[idx] <= 1'b0;
                end
                // last neuron's bit comes straight from the datapath so spikes is complete in DONE
                if (last) begin
                    state  <= DONE;
                    spikes <= {fire, spk[N_NEURONS-2:0]};
                end
            end
        end
    end
endmodule
